// File: rtl/key_press_conditioner_if.sv
// rtl/key_press_conditioner_if.sv - player-input bundle between the game datapath and the key conditioner
interface key_press_conditioner_if;
    logic       iEnable;
    logic [3:0] iKey;
    logic       oPress;
    logic [1:0] oKeyId;
    logic       oMulti;
    logic [3:0] oKeysDown;
    logic       oArmed;

    modport master (
        output iEnable,
        output iKey,
        input  oPress,
        input  oKeyId,
        input  oMulti,
        input  oKeysDown,
        input  oArmed
    );

    modport slave (
        input  iEnable,
        input  iKey,
        output oPress,
        output oKeyId,
        output oMulti,
        output oKeysDown,
        output oArmed
    );
endinterface

// File: rtl/key_press_conditioner.sv
// rtl/key_press_conditioner.sv - synchronises and debounces four push-buttons into single press events
module key_press_conditioner #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 19,
    parameter bit KEY_ACTIVE_LOW  = 1'b1
) (
    input  logic                    iClock,
    input  logic                    iReset,
    key_press_conditioner_if.slave  bus
);
    localparam logic [3:0]       RELEASED_RAW = KEY_ACTIVE_LOW ? 4'hF : 4'h0;
    localparam logic [CNT_W-1:0] CNT_LAST     = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_DISARMED,
        S_WAIT_RELEASE,
        S_ARMED,
        S_HELD
    } state_t;

    logic [3:0]       r_sync1;
    logic [3:0]       r_sync2;
    logic [3:0]       r_db;
    logic [3:0]       r_db_prev;
    logic [CNT_W-1:0] r_cnt [4];
    state_t           r_state;
    logic             r_press;
    logic             r_multi;
    logic [1:0]       r_key_id;

    logic [3:0]       w_s;
    logic [3:0]       w_rise;
    logic [2:0]       w_rise_cnt;
    logic [1:0]       w_rise_idx;
    state_t           w_state_nxt;
    logic             w_press_nxt;
    logic             w_multi_nxt;
    logic [1:0]       w_key_id_nxt;

    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            r_sync1 <= RELEASED_RAW;
            r_sync2 <= RELEASED_RAW;
        end else begin
            r_sync1 <= bus.iKey;
            r_sync2 <= r_sync1;
        end
    end

    assign w_s = KEY_ACTIVE_LOW ? ~r_sync2 : r_sync2;

    // A level is accepted only after it has differed from db for DEBOUNCE_CYCLES consecutive edges.
    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            r_db      <= 4'h0;
            r_db_prev <= 4'h0;
            for (int k = 0; k < 4; k++) r_cnt[k] <= '0;
        end else begin
            r_db_prev <= r_db;
            for (int k = 0; k < 4; k++) begin
                if (w_s[k] == r_db[k]) begin
                    r_cnt[k] <= '0;
                end else if (r_cnt[k] == CNT_LAST) begin
                    r_db[k]  <= w_s[k];
                    r_cnt[k] <= '0;
                end else begin
                    r_cnt[k] <= r_cnt[k] + CNT_W'(1);
                end
            end
        end
    end

    assign w_rise     = r_db & ~r_db_prev;
    assign w_rise_cnt = {2'b00, w_rise[0]} + {2'b00, w_rise[1]}
                      + {2'b00, w_rise[2]} + {2'b00, w_rise[3]};

    always_comb begin
        w_rise_idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (w_rise[i]) w_rise_idx = 2'(i);
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_press_nxt  = 1'b0;
        w_multi_nxt  = 1'b0;
        w_key_id_nxt = r_key_id;
        if (!bus.iEnable) begin
            w_state_nxt = S_DISARMED;
        end else begin
            case (r_state)
                S_DISARMED: w_state_nxt = S_WAIT_RELEASE;
                S_WAIT_RELEASE: begin
                    if (r_db == 4'h0) w_state_nxt = S_ARMED;
                end
                S_ARMED: begin
                    if (w_rise_cnt == 3'd1) begin
                        w_press_nxt  = 1'b1;
                        w_key_id_nxt = w_rise_idx;
                        w_state_nxt  = S_HELD;
                    end else if (w_rise_cnt >= 3'd2) begin
                        w_multi_nxt = 1'b1;
                        w_state_nxt = S_WAIT_RELEASE;
                    end
                end
                S_HELD: begin
                    if (r_db == 4'h0) w_state_nxt = S_ARMED;
                end
                default: w_state_nxt = S_DISARMED;
            endcase
        end
    end

    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            r_state  <= S_DISARMED;
            r_press  <= 1'b0;
            r_multi  <= 1'b0;
            r_key_id <= 2'd0;
        end else begin
            r_state  <= w_state_nxt;
            r_press  <= w_press_nxt;
            r_multi  <= w_multi_nxt;
            r_key_id <= w_key_id_nxt;
        end
    end

    assign bus.oPress    = r_press;
    assign bus.oMulti    = r_multi;
    assign bus.oKeyId    = r_key_id;
    assign bus.oKeysDown = r_db;
    assign bus.oArmed    = (r_state == S_ARMED);
endmodule

// File: tb/tb_key_press_conditioner.sv
// tb/tb_key_press_conditioner.sv - directed and randomized checks of key_press_conditioner against a behavioural model
module tb_key_press_conditioner;
    localparam int D = 4;

    logic clk;
    logic rst;
    key_press_conditioner_if bus ();

    key_press_conditioner #(
        .DEBOUNCE_CYCLES (D),
        .CNT_W           (3),
        .KEY_ACTIVE_LOW  (1'b1)
    ) dut (
        .iClock (clk),
        .iReset (rst),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    // Behavioural model: phase 0 idle, 1 waiting for all keys up, 2 ready, 3 key held
    logic [3:0] m_sync1, m_sync2, m_db, m_db_prev;
    logic [3:0] m_hist[$];
    int         m_phase;
    logic       m_press, m_multi;
    logic [1:0] m_id;

    task automatic model_reset();
        m_sync1 = 4'hF;
        m_sync2 = 4'hF;
        m_db = 4'h0;
        m_db_prev = 4'h0;
        m_hist.delete();
        m_phase = 0;
        m_press = 1'b0;
        m_multi = 1'b0;
        m_id = 2'd0;
    endtask

    task automatic model_edge();
        logic [3:0] s, new_db, rise;
        int n_rise;
        bit all_differ;
        if (rst) begin
            model_reset();
            return;
        end
        s = ~m_sync2;
        m_hist.push_back(s);
        if (m_hist.size() > D) void'(m_hist.pop_front());
        new_db = m_db;
        if (m_hist.size() == D) begin
            for (int k = 0; k < 4; k++) begin
                all_differ = 1'b1;
                for (int j = 0; j < D; j++) if (m_hist[j][k] == m_db[k]) all_differ = 1'b0;
                if (all_differ) new_db[k] = ~m_db[k];
            end
        end
        rise = m_db & ~m_db_prev;
        n_rise = $countones(rise);
        m_press = 1'b0;
        m_multi = 1'b0;
        if (!bus.iEnable) m_phase = 0;
        else if (m_phase == 0) m_phase = 1;
        else if ((m_phase == 1 || m_phase == 3) && m_db == 4'h0) m_phase = 2;
        else if (m_phase == 2 && n_rise == 1) begin
            m_press = 1'b1;
            for (int k = 0; k < 4; k++) if (rise[k]) m_id = 2'(k);
            m_phase = 3;
        end else if (m_phase == 2 && n_rise >= 2) begin
            m_multi = 1'b1;
            m_phase = 1;
        end
        m_db_prev = m_db;
        m_db = new_db;
        m_sync2 = m_sync1;
        m_sync1 = bus.iKey;
    endtask

    task automatic compare_all(input string where);
        check_eq({where, "_press"}, 32'(bus.oPress), 32'(m_press));
        check_eq({where, "_multi"}, 32'(bus.oMulti), 32'(m_multi));
        check_eq({where, "_id"}, 32'(bus.oKeyId), 32'(m_id));
        check_eq({where, "_down"}, 32'(bus.oKeysDown), 32'(m_db));
        check_eq({where, "_armed"}, 32'(bus.oArmed), 32'(m_phase == 2));
        check_eq({where, "_excl"}, 32'(bus.oPress & bus.oMulti), 32'd0);
    endtask

    task automatic tick(input string where);
        model_edge();
        @(posedge clk);
        @(negedge clk);
        compare_all(where);
    endtask

    task automatic hold(input logic en, input logic [3:0] key, input int n, input string where);
        bus.iEnable = en;
        bus.iKey = key;
        repeat (n) tick(where);
    endtask

    task automatic do_reset(input string where);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        compare_all(where);
        @(negedge clk);
        compare_all(where);
        rst = 1'b0;
    endtask

    int n_press;
    int press_at;
    logic [3:0] pat;

    initial begin
        rst = 1'b1;
        bus.iEnable = 1'b0;
        bus.iKey = 4'hF;
        model_reset();
        #1;
        compare_all("reset");
        @(negedge clk);
        rst = 1'b0;

        hold(1'b1, 4'hF, 10, "s1_idle");
        bus.iKey = 4'b1101;
        n_press = 0;
        press_at = 0;
        for (int i = 1; i <= 20; i++) begin
            tick("s1");
            if (bus.oPress) begin
                n_press++;
                press_at = i;
            end
        end
        check_eq("s1_press_count", 32'(n_press), 32'd1);
        check_eq("s1_press_edge", 32'(press_at), 32'd7);
        check_eq("s1_key_id", 32'(bus.oKeyId), 32'd1);
        check_eq("s1_keys_down", 32'(bus.oKeysDown), 32'b0010);
        hold(1'b1, 4'hF, 10, "s1_rel");

        hold(1'b1, 4'b1110, 3, "s2_glitch");
        hold(1'b1, 4'hF, 10, "s2_rel");
        check_eq("s2_keys_down", 32'(bus.oKeysDown), 32'd0);

        hold(1'b1, 4'b0110, 15, "s3_multi");
        hold(1'b1, 4'hF, 15, "s3_rel");
        hold(1'b1, 4'b0111, 15, "s3_key3");
        hold(1'b1, 4'hF, 15, "s3_rel2");

        hold(1'b0, 4'b1011, 15, "s4_held_off");
        hold(1'b1, 4'b1011, 15, "s4_held_on");
        hold(1'b1, 4'hF, 15, "s4_rel");
        hold(1'b1, 4'b1011, 15, "s4_key2");
        hold(1'b1, 4'hF, 15, "s4_rel2");

        hold(1'b1, 4'b1110, 15, "s5_key0");
        hold(1'b1, 4'b0110, 15, "s5_plus3");
        hold(1'b1, 4'hF, 15, "s5_rel");
        hold(1'b1, 4'b0111, 15, "s5_key3");
        hold(1'b1, 4'hF, 15, "s5_rel2");

        hold(1'b1, 4'b1110, 3, "s6_mid");
        do_reset("s6_rst1");
        hold(1'b1, 4'b1110, 15, "s6_held");
        do_reset("s6_rst2");
        hold(1'b1, 4'b1110, 15, "s6_redeb");
        hold(1'b1, 4'hF, 15, "s6_rel");

        pat = 4'hF;
        for (int seg = 0; seg < 600; seg++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3: pat = 4'hF;
                4, 5, 6:    pat = ~(4'b0001 << $urandom_range(0, 3));
                7, 8:       pat = 4'($urandom_range(0, 15));
                default:    pat = pat ^ (4'b0001 << $urandom_range(0, 3));
            endcase
            if ($urandom_range(0, 99) == 0) do_reset("rnd_rst");
            hold(($urandom_range(0, 19) != 0), pat, $urandom_range(1, 12), "rnd");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
